pwm_reg_arbiter: RTL and testbench

- Owns the PWM configuration register bank: en_out[15:0], en_pwm_mode[15:0], pwm_duty_cycle[7:0].
- Shares write access to the bank between N_REQ write masters (SPI peripheral, on-chip sequencer, debug) using round-robin arbitration and a valid/ready handshake.
- Sits between the write masters and the PWM generator, and is the only block that drives the bank.

---
 rtl/pwm_reg_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_pwm_reg_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_reg_arbiter.sv
// pwm_reg_arbiter
// Owns the PWM configuration bank (en_out, en_pwm_mode, pwm_duty_cycle) and
// shares write access between N_REQ masters with round-robin arbitration.
// Each accepted write takes two cycles: IDLE picks a requester, GRANT
// presents a registered ready and performs the byte write.
//
// state | meaning
// IDLE  | no grant outstanding; arbitrate among valid requesters
// GRANT | req_ready[grant_id] high; write (or flag) on this cycle's edge
//
// Build option: define PWM_REG_SHADOW_COMMIT_EN to route writes into shadow
// bytes that are copied to the visible outputs after a commit_strobe.
module pwm_reg_arbiter #(
  parameter int N_REQ = 2,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef PWM_REG_SHADOW_COMMIT_EN
  input  logic               commit_strobe,
`endif
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*7-1:0] req_addr,
  input  logic [N_REQ*8-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [15:0]        en_out,
  output logic [15:0]        en_pwm_mode,
  output logic [7:0]         pwm_duty_cycle,
  output logic [PTR_W-1:0]   grant_id,
  output logic               busy,
  output logic               wr_err
);

  typedef enum logic {IDLE, GRANT} state_t;

  // Requester count at the width of the wrap-around sum used in the search.
  localparam logic [PTR_W:0] N_REQ_W = (PTR_W+1)'(N_REQ);
  localparam logic [PTR_W-1:0] LAST_ID = PTR_W'(N_REQ-1);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] grant_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] ready_d;
  logic             busy_d;
  logic             wr_err_d;

  logic [PTR_W-1:0] pick;
  logic             any_valid;
  logic             sel_valid;
  logic [6:0]       sel_addr;
  logic [7:0]       sel_data;
  logic [4:0]       byte_we;

  // Visible bank bytes: 0 en_out lo, 1 en_out hi, 2 mode lo, 3 mode hi, 4 duty.
  logic [7:0]       bank_q [5];
  logic [7:0]       wr_next [5];

  assign any_valid = |req_valid;
  assign sel_valid = req_valid[grant_id];
  assign sel_addr  = req_addr[int'(grant_id)*7 +: 7];
  assign sel_data  = req_data[int'(grant_id)*8 +: 8];

  // Cyclic search from rr_ptr: highest offset first so the nearest valid wins.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;
    pick = rr_ptr_q;
    sum  = '0;
    cand = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (sum >= N_REQ_W) begin
        sum = sum - N_REQ_W;
      end
      cand = sum[PTR_W-1:0];
      if (req_valid[cand]) begin
        pick = cand;
      end
    end
  end

  // Next-state, registered-output values and byte write enables.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_id;
    rr_ptr_d = rr_ptr_q;
    ready_d  = '0;
    busy_d   = 1'b0;
    wr_err_d = 1'b0;
    byte_we  = '0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d       = pick;
          ready_d[pick] = 1'b1;
          busy_d        = 1'b1;
          state_d       = GRANT;
        end
      end
      GRANT: begin
        // A requester that dropped valid gets neither a write nor an error.
        if (sel_valid) begin
          if (sel_addr < 7'd5) begin
            byte_we[sel_addr[2:0]] = 1'b1;
          end else begin
            wr_err_d = 1'b1;
          end
        end
        rr_ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, grant bookkeeping and the Moore handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_id  <= '0;
      rr_ptr_q  <= '0;
      req_ready <= '0;
      busy      <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_id  <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      req_ready <= ready_d;
      busy      <= busy_d;
      wr_err    <= wr_err_d;
    end
  end

`ifdef PWM_REG_SHADOW_COMMIT_EN
  logic [7:0] shadow_q [5];

  // Shadow bytes after this cycle's write; a same-cycle commit sees this value.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      wr_next[i] = byte_we[i] ? sel_data : shadow_q[i];
    end
  end

  // Shadow bank tracks writes; the visible bank copies it on commit_strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        shadow_q[i] <= '0;
        bank_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        shadow_q[i] <= wr_next[i];
        if (commit_strobe) begin
          bank_q[i] <= wr_next[i];
        end
      end
    end
  end
`else
  // Visible bytes after this cycle's write; untouched bytes hold.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      wr_next[i] = byte_we[i] ? sel_data : bank_q[i];
    end
  end

  // Visible bank updated directly by granted writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        bank_q[i] <= wr_next[i];
      end
    end
  end
`endif

  assign en_out         = {bank_q[1], bank_q[0]};
  assign en_pwm_mode    = {bank_q[3], bank_q[2]};
  assign pwm_duty_cycle = bank_q[4];

endmodule

// File: tb/tb_pwm_reg_arbiter.sv
// Directed bench for pwm_reg_arbiter with N_REQ=2. Inputs change 1ns after
// the rising edge and outputs are sampled at the same point.
module tb_pwm_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  vld;
  logic [13:0] addr;
  logic [15:0] data;
  logic [1:0]  rdy;
  logic [15:0] en_out;
  logic [15:0] en_pwm_mode;
  logic [7:0]  duty;
  logic        gid;
  logic        busy;
  logic        wr_err;
`ifdef PWM_REG_SHADOW_COMMIT_EN
  logic        commit;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pwm_reg_arbiter #(.N_REQ(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef PWM_REG_SHADOW_COMMIT_EN
    .commit_strobe  (commit),
`endif
    .req_valid      (vld),
    .req_addr       (addr),
    .req_data       (data),
    .req_ready      (rdy),
    .en_out         (en_out),
    .en_pwm_mode    (en_pwm_mode),
    .pwm_duty_cycle (duty),
    .grant_id       (gid),
    .busy           (busy),
    .wr_err         (wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [6:0] a, input logic [7:0] d);
    addr[i*7 +: 7] = a;
    data[i*8 +: 8] = d;
  endtask

  initial begin
    rst_n = 1'b0;
    vld   = '0;
    addr  = '0;
    data  = '0;
`ifdef PWM_REG_SHADOW_COMMIT_EN
    commit = 1'b1;
`endif
    step();
    step();
    chk("rst_en_out", en_out, 0);
    chk("rst_mode", en_pwm_mode, 0);
    chk("rst_duty", duty, 0);
    chk("rst_ready", rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_gid", gid, 0);
    rst_n = 1'b1;
    step();

    // Single write: duty <- 0x80 by req0
    set_req(0, 7'h04, 8'h80);
    vld = 2'b01;
    chk("sw_busy_T", busy, 0);
    step();
    chk("sw_ready_T1", rdy, 2'b01);
    chk("sw_busy_T1", busy, 1);
    chk("sw_duty_T1", duty, 8'h00);
    step();
    chk("sw_duty_T2", duty, 8'h80);
    chk("sw_busy_T2", busy, 0);
    chk("sw_ready_T2", rdy, 0);
    vld = 2'b00;
    step();

    // Contention from rr_ptr=0 after reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_req(0, 7'h00, 8'hAA);
    set_req(1, 7'h01, 8'h55);
    vld = 2'b11;
    step();
    chk("ct_gid_first", gid, 0);
    chk("ct_ready_first", rdy, 2'b01);
    step();
    chk("ct_en_mid", en_out, 16'h00AA);
    vld = 2'b10;
    step();
    chk("ct_gid_second", gid, 1);
    chk("ct_ready_second", rdy, 2'b10);
    step();
    chk("ct_en_out", en_out, 16'h55AA);
    vld = 2'b00;
    step();

    // req0 writes mode lo to move rr_ptr to 1, then contention grants req1 first
    set_req(0, 7'h02, 8'h34);
    vld = 2'b01;
    step();
    step();
    vld = 2'b00;
    step();
    set_req(0, 7'h03, 8'h12);
    set_req(1, 7'h04, 8'h77);
    vld = 2'b11;
    step();
    chk("rr1_gid_first", gid, 1);
    chk("rr1_ready_first", rdy, 2'b10);
    step();
    chk("rr1_duty", duty, 8'h77);
    chk("rr1_mode_mid", en_pwm_mode, 16'h0034);
    vld = 2'b01;
    step();
    chk("rr1_ready_second", rdy, 2'b01);
    step();
    chk("rr1_mode", en_pwm_mode, 16'h1234);
    vld = 2'b00;
    step();

    // Byte isolation on en_pwm_mode
    set_req(0, 7'h02, 8'hCD);
    vld = 2'b01;
    step();
    step();
    chk("iso_mode", en_pwm_mode, 16'h12CD);
    chk("iso_en_out", en_out, 16'h55AA);
    chk("iso_duty", duty, 8'h77);
    vld = 2'b00;
    step();

    // Unmapped address by req1
    set_req(1, 7'h10, 8'hFF);
    vld = 2'b10;
    step();
    chk("um_ready", rdy, 2'b10);
    chk("um_err_T1", wr_err, 0);
    step();
    chk("um_err_T2", wr_err, 1);
    chk("um_en_out", en_out, 16'h55AA);
    chk("um_mode", en_pwm_mode, 16'h12CD);
    chk("um_duty", duty, 8'h77);
    vld = 2'b00;
    step();
    chk("um_err_T3", wr_err, 0);

    // req1 drops valid during GRANT: no write, no error, req0 granted next
    set_req(1, 7'h04, 8'h11);
    vld = 2'b10;
    step();
    chk("vd_ready", rdy, 2'b10);
    vld = 2'b00;
    step();
    chk("vd_duty", duty, 8'h77);
    chk("vd_err", wr_err, 0);
    chk("vd_busy", busy, 0);
    set_req(0, 7'h00, 8'h0F);
    set_req(1, 7'h01, 8'h33);
    vld = 2'b11;
    step();
    chk("vd_next_gid", gid, 0);
    chk("vd_next_ready", rdy, 2'b01);
    step();
    chk("vd_en_out", en_out, 16'h550F);
    vld = 2'b00;
    step();

    // Reset during GRANT abandons the write
    set_req(0, 7'h04, 8'hEE);
    vld = 2'b01;
    step();
    chk("rg_busy", busy, 1);
    rst_n = 1'b0;
    step();
    chk("rg_duty", duty, 0);
    chk("rg_en_out", en_out, 0);
    chk("rg_mode", en_pwm_mode, 0);
    chk("rg_busy_after", busy, 0);
    chk("rg_ready", rdy, 0);
    rst_n = 1'b1;
    vld = 2'b00;
    step();
    chk("rg_duty_hold", duty, 0);

`ifdef PWM_REG_SHADOW_COMMIT_EN
    // Shadow commit: write lands in shadow, appears after commit_strobe
    commit = 1'b0;
    set_req(0, 7'h04, 8'h40);
    vld = 2'b01;
    step();
    step();
    chk("sh_duty_uncommitted", duty, 8'h00);
    vld = 2'b00;
    commit = 1'b1;
    step();
    chk("sh_duty_committed", duty, 8'h40);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
